// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the shared data-memory port: the pipeline (port 0) has fixed
// priority, and the loader/debug master (port 1) is forced through after a bounded wait.
module data_mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_WAIT      = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,

    input  logic                     i_p0_req,
    input  logic                     i_p0_we,
    input  logic [2:0]               i_p0_funct3,
    input  logic [ADDRESS_WIDTH-1:0] i_p0_addr,
    input  logic [DATA_WIDTH-1:0]    i_p0_wdata,
    output logic                     o_p0_gnt,
    output logic                     o_p0_rvalid,
    output logic [DATA_WIDTH-1:0]    o_p0_rdata,

    input  logic                     i_p1_req,
    input  logic                     i_p1_we,
    input  logic [2:0]               i_p1_funct3,
    input  logic [ADDRESS_WIDTH-1:0] i_p1_addr,
    input  logic [DATA_WIDTH-1:0]    i_p1_wdata,
    output logic                     o_p1_gnt,
    output logic                     o_p1_rvalid,
    output logic [DATA_WIDTH-1:0]    o_p1_rdata,

    output logic                     o_stall,
    output logic                     o_misalign_err,

    output logic                     o_mem_en,
    output logic                     o_mem_we,
    output logic [2:0]               o_mem_funct3,
    output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]    o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]    i_mem_rdata
);

    localparam logic [3:0] WAIT_SAT   = 4'd15;
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]               r_wait_cnt;
    logic                     r_p0_rvalid;
    logic                     r_p1_rvalid;
    logic [DATA_WIDTH-1:0]    r_p0_rdata;
    logic [DATA_WIDTH-1:0]    r_p1_rdata;
    logic                     r_misalign_err;

    logic                     w_force1;
    logic                     w_p0_gnt;
    logic                     w_p1_gnt;
    logic                     w_any_gnt;
    logic                     w_sel_we;
    logic [2:0]               w_sel_funct3;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_wdata;
    logic                     w_misaligned;
    logic                     w_aligned;
    logic                     w_p0_rd;
    logic                     w_p1_rd;

    // funct3[1:0]=11 has no legal size, so it is rejected like any misaligned access.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    assign w_force1  = (r_wait_cnt >= WAIT_LIMIT);
    assign w_p1_gnt  = i_p1_req && (!i_p0_req || w_force1);
    assign w_p0_gnt  = i_p0_req && !w_p1_gnt;
    assign w_any_gnt = w_p0_gnt || w_p1_gnt;

    always_comb begin
        w_sel_we     = 1'b0;
        w_sel_funct3 = '0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        if (w_p1_gnt) begin
            w_sel_we     = i_p1_we;
            w_sel_funct3 = i_p1_funct3;
            w_sel_addr   = i_p1_addr;
            w_sel_wdata  = i_p1_wdata;
        end else if (w_p0_gnt) begin
            w_sel_we     = i_p0_we;
            w_sel_funct3 = i_p0_funct3;
            w_sel_addr   = i_p0_addr;
            w_sel_wdata  = i_p0_wdata;
        end
    end

    assign w_misaligned = w_any_gnt && is_misaligned(w_sel_funct3, w_sel_addr[1:0]);
    assign w_aligned    = w_any_gnt && !w_misaligned;
    assign w_p0_rd      = w_p0_gnt && !i_p0_we;
    assign w_p1_rd      = w_p1_gnt && !i_p1_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (i_p1_req && !w_p1_gnt) begin
            if (r_wait_cnt != WAIT_SAT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // A misaligned read still completes, returning zero, so the requester never hangs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p0_rvalid    <= 1'b0;
            r_p1_rvalid    <= 1'b0;
            r_p0_rdata     <= '0;
            r_p1_rdata     <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_p0_rvalid    <= w_p0_rd;
            r_p1_rvalid    <= w_p1_rd;
            r_misalign_err <= w_misaligned;
            if (w_p0_rd) begin
                r_p0_rdata <= w_aligned ? i_mem_rdata : '0;
            end
            if (w_p1_rd) begin
                r_p1_rdata <= w_aligned ? i_mem_rdata : '0;
            end
        end
    end

    assign o_p0_gnt       = w_p0_gnt;
    assign o_p1_gnt       = w_p1_gnt;
    assign o_stall        = i_p0_req && !w_p0_gnt;
    assign o_p0_rvalid    = r_p0_rvalid;
    assign o_p1_rvalid    = r_p1_rvalid;
    assign o_p0_rdata     = r_p0_rdata;
    assign o_p1_rdata     = r_p1_rdata;
    assign o_misalign_err = r_misalign_err;

    assign o_mem_en     = w_aligned;
    assign o_mem_we     = w_aligned && w_sel_we;
    assign o_mem_funct3 = w_sel_funct3;
    assign o_mem_addr   = w_sel_addr;
    assign o_mem_wdata  = w_sel_wdata;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory port between two requesters:
  - port 0: the pipeline memory stage;
  - port 1: the program loader / debug master.
- Sits between the requesters and the data memory.
- Default policy is fixed priority to the pipeline. An anti-starvation counter forces a port-1 grant after a bounded wait.
- Checks alignment, returns registered read data one cycle after grant, and stalls the pipeline when it loses arbitration.

Parameters:
- ADDRESS_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data word width.
- MAX_WAIT, 4, number of consecutive cycles port 1 may be denied before it is forced a grant (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  pipeline access request.
- p0_we  in  1  pipeline write (1) / read (0).
- p0_funct3  in  3  access size/sign, RISC-V load/store encoding.
- p0_addr  in  ADDRESS_WIDTH  pipeline byte address.
- p0_wdata  in  DATA_WIDTH  pipeline store data.
- p0_gnt  out  1  pipeline request accepted this cycle.
- p0_rvalid  out  1  pipeline read data valid.
- p0_rdata  out  DATA_WIDTH  pipeline read data.
- p1_req, p1_we, p1_funct3, p1_addr, p1_wdata  in  1/1/3/ADDRESS_WIDTH/DATA_WIDTH  loader/debug request, same meaning as the p0 inputs.
- p1_gnt, p1_rvalid, p1_rdata  out  1/1/DATA_WIDTH  loader/debug grant and read return.
- stall  out  1  p0_req && !p0_gnt.
- misalign_err  out  1  registered pulse: granted access was misaligned.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_funct3  out  3  forwarded access size.
- mem_addr  out  ADDRESS_WIDTH  forwarded address.
- mem_wdata  out  DATA_WIDTH  forwarded store data.
- mem_rdata  in  DATA_WIDTH  memory read data, asynchronous (valid same cycle as address).

Behaviour:
- Reset (async, rst_n=0): wait_cnt=0, p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0, misalign_err=0.
  - Combinational outputs follow the inputs and the reset state.
  - Reset mid-access aborts it: no rvalid is produced after release.
- Arbitration is combinational on the current cycle:
  - force1 = (wait_cnt >= MAX_WAIT).
  - p1_gnt = p1_req && (!p0_req || force1).
  - p0_gnt = p0_req && !p1_gnt.
  - At most one grant per cycle.
- wait_cnt:
  - Increments (saturating at 15) when p1_req && !p1_gnt.
  - Clears on p1_gnt or when p1_req=0.
- Alignment check on the granted request:
  - Halfword (funct3[1:0]=01) misaligned if addr[0]=1.
  - Word (funct3[1:0]=10) misaligned if addr[1:0]!=0.
  - Byte accesses are never misaligned.
  - funct3[1:0]=11 is treated as misaligned.
- Memory side:
  - mem_en = grant && aligned.
  - mem_we = mem_en && granted we.
  - mem_funct3, mem_addr and mem_wdata are muxed from the granted port; they are 0 when there is no grant.
- Misaligned grant:
  - The request is still granted, so the requester does not hang.
  - mem_en=0, so there is no memory write.
  - misalign_err=1 for the next cycle.
  - A misaligned read still returns rvalid with rdata=0.
- Read return: on an aligned granted read, mem_rdata is captured into that port's rdata register; that port's rvalid=1 in the following cycle only.
- Write return: no rvalid.
- Read-data registers:
  - Hold their value until the next read return to the same port.
  - rvalid is a single-cycle pulse.
- Back-to-back:
  - Grants may occur every cycle.
  - A read return and a new grant to the same port in consecutive cycles are independent.
- Simultaneous requests:
  - Without force: p0 wins and p1 waits.
  - With force: p1 wins, stall=1 for that cycle, and wait_cnt returns to 0.
- Inputs are sampled only in the grant cycle. A requester must hold req and payload stable until it sees gnt.

Test Plan:
1. p0 only: read, addr=0x8, funct3=010, mem_rdata=0xDEADBEEF.
   - Same cycle: p0_gnt=1, mem_en=1, mem_addr=0x8.
   - Next cycle: p0_rvalid=1, p0_rdata=0xDEADBEEF.
2. p1 only: write, addr=0x4, funct3=000, wdata=0xAB.
   - Same cycle: p1_gnt=1, mem_we=1, mem_wdata=0xAB.
   - Next cycle: no rvalid.
3. Both requesting continuously, MAX_WAIT=4.
   - p0 is granted for 4 cycles (stall=0); p1 is granted on cycle 5 (stall=1).
   - The pattern then repeats 4:1.
4. Misaligned p0 word store to addr=0x6.
   - p0_gnt=1, mem_en=0, memory unchanged.
   - misalign_err=1 next cycle.
   - A subsequent aligned read of 0x4 returns the old value.
5. Reset asserted during a granted read (rst_n low for 1 cycle mid-cycle).
   - Outputs clear immediately: p0_rvalid=0, p0_rdata=0.
   - wait_cnt=0 after release, and no spurious rvalid.
6. p1 denied 2 cycles, then drops req for 1 cycle, then re-requests against constant p0_req.
   - wait_cnt restarts from 0, so p1 waits a full 4 cycles before being granted.
